// File: rtl/rx_bit_timer.sv
// Programmable receive bit timer: mid-bit sample, end-of-bit shift and packet-done strobes.
// Strobes are combinational decodes of registered state; packet_done lands bpp*cpb cycles after start.
// enable_timer low aborts a packet mid-flight; a finished packet waits for enable_timer low before restarting.
module rx_bit_timer #(
  parameter int CW = 14,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_timer,
  input  logic [CW-1:0] cfg_clks_per_bit,
  input  logic [BW-1:0] cfg_bits_per_packet,
  output logic          sample_strobe,
  output logic          shift_strobe,
  output logic          packet_done,
  output logic [BW-1:0] bit_index,
  output logic          busy,
  output logic          cfg_error
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [CW-1:0] cpb, cpb_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic [BW-1:0] bpp, bpp_nxt;

  logic cfg_legal;
  logic bit_end;
  logic last_bit;

  assign cfg_legal = (cfg_clks_per_bit >= CW'(2)) && (cfg_bits_per_packet != '0);
  assign bit_end   = (clk_cnt == cpb);
  assign last_bit  = (bit_cnt == bpp - BW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      cpb     <= '0;
      bpp     <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      cpb     <= cpb_nxt;
      bpp     <= bpp_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    clk_cnt_nxt   = clk_cnt;
    bit_cnt_nxt   = bit_cnt;
    cpb_nxt       = cpb;
    bpp_nxt       = bpp;
    sample_strobe = 1'b0;
    shift_strobe  = 1'b0;
    packet_done   = 1'b0;
    cfg_error     = 1'b0;

    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (enable_timer) begin
          if (cfg_legal) begin
            cpb_nxt     = cfg_clks_per_bit;
            bpp_nxt     = cfg_bits_per_packet;
            clk_cnt_nxt = CW'(1);
            state_nxt   = RUN;
          end else begin
            cfg_error = 1'b1;
          end
        end
      end

      RUN: begin
        if (!enable_timer) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          sample_strobe = (clk_cnt == (cpb >> 1));
          if (bit_end) begin
            shift_strobe = 1'b1;
            clk_cnt_nxt  = CW'(1);
            // The final bit keeps bit_cnt below bpp so DONE never shows an out-of-range index.
            if (last_bit) begin
              packet_done = 1'b1;
              state_nxt   = DONE;
            end else begin
              bit_cnt_nxt = bit_cnt + BW'(1);
            end
          end else begin
            clk_cnt_nxt = clk_cnt + CW'(1);
          end
        end
      end

      DONE: begin
        if (!enable_timer) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end
      end

      default: begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

  assign bit_index = bit_cnt;
  assign busy      = (state == RUN);

endmodule

// File: tb/tb_rx_bit_timer.sv
// Bench for rx_bit_timer: arithmetic packet model checked every cycle, plus hand-computed strobe positions.
module tb_rx_bit_timer;

  localparam int CW = 14;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable_timer = 1'b0;
  logic [CW-1:0] cfg_clks_per_bit = CW'(10);
  logic [BW-1:0] cfg_bits_per_packet = BW'(9);
  logic          sample_strobe, shift_strobe, packet_done, busy, cfg_error;
  logic [BW-1:0] bit_index;

  rx_bit_timer #(.CW(CW), .BW(BW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable_timer        (enable_timer),
    .cfg_clks_per_bit    (cfg_clks_per_bit),
    .cfg_bits_per_packet (cfg_bits_per_packet),
    .sample_strobe       (sample_strobe),
    .shift_strobe        (shift_strobe),
    .packet_done         (packet_done),
    .bit_index           (bit_index),
    .busy                (busy),
    .cfg_error           (cfg_error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Packet model: phase plus the 1-based cycle number within the packet.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      m_n = 0;
  int      m_cpb = 0;
  int      m_bpp = 0;

  function automatic bit legal(input int c, input int b);
    return (c >= 2) && (b != 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = M_IDLE;
      m_n     = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (enable_timer && legal(int'(cfg_clks_per_bit), int'(cfg_bits_per_packet))) begin
          m_cpb   = int'(cfg_clks_per_bit);
          m_bpp   = int'(cfg_bits_per_packet);
          m_phase = M_RUN;
          m_n     = 1;
        end
        M_RUN: begin
          if (!enable_timer)             begin m_phase = M_IDLE; m_n = 0; end
          else if (m_n == m_bpp * m_cpb) m_phase = M_DONE;
          else                           m_n++;
        end
        default: if (!enable_timer) m_phase = M_IDLE;
      endcase
    end
  end

  // Event logs indexed by cycle number relative to the latest packet start.
  int tick = 0;
  int base = -1000;
  logic smp_log [0:255];
  logic shf_log [0:255];
  logic dn_log  [0:255];

  always @(posedge clk) tick <= tick + 1;

  bit e_act;
  int rel;
  always @(negedge clk) begin
    rel = tick - base;
    if (rel >= 0 && rel < 256) begin
      smp_log[rel] = sample_strobe;
      shf_log[rel] = shift_strobe;
      dn_log[rel]  = packet_done;
    end
    if (chk_en) begin
      e_act = (m_phase == M_RUN) && enable_timer;
      chk("m_sample", sample_strobe, e_act && (m_n % m_cpb == m_cpb / 2));
      chk("m_shift",  shift_strobe,  e_act && (m_n % m_cpb == 0));
      chk("m_done",   packet_done,   e_act && (m_n == m_bpp * m_cpb));
      chk("m_busy",   busy,          m_phase == M_RUN);
      chk("m_cfgerr", cfg_error, (m_phase == M_IDLE) && enable_timer &&
          !legal(int'(cfg_clks_per_bit), int'(cfg_bits_per_packet)));
      if (m_phase == M_RUN)       chk("m_bitidx", bit_index, (m_n - 1) / m_cpb);
      else if (m_phase == M_IDLE) chk("m_bitidx", bit_index, 0);
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic start_pkt(input int c, input int b);
    cfg_clks_per_bit    = CW'(c);
    cfg_bits_per_packet = BW'(b);
    base                = tick;
    enable_timer        = 1'b1;
  endtask

  function automatic int count_log(input int which, input int hi);
    int s = 0;
    for (int i = 1; i <= hi; i++)
      s += (which == 0) ? int'(smp_log[i]) : (which == 1) ? int'(shf_log[i]) : int'(dn_log[i]);
    return s;
  endfunction

  initial begin
    step(3);
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_bitidx", bit_index, 0);
    rst = 1'b0;
    step(1);

    // Default packet cpb=10, bpp=9
    start_pkt(10, 9);
    step(100);
    chk("dflt_smp5", smp_log[5], 1);
    chk("dflt_smp85", smp_log[85], 1);
    chk("dflt_shf10", shf_log[10], 1);
    chk("dflt_shf90", shf_log[90], 1);
    chk("dflt_dn90", dn_log[90], 1);
    chk("dflt_nsmp", count_log(0, 100), 9);
    chk("dflt_nshf", count_log(1, 100), 9);
    chk("dflt_ndn", count_log(2, 100), 1);
    chk("dflt_busy100", busy, 0);
    enable_timer = 1'b0;
    step(1);

    // Odd and minimum periods
    start_pkt(3, 2);
    step(8);
    chk("c3_smp1", smp_log[1], 1);
    chk("c3_smp4", smp_log[4], 1);
    chk("c3_shf3", shf_log[3], 1);
    chk("c3_shf6", shf_log[6], 1);
    chk("c3_dn6", dn_log[6], 1);
    chk("c3_nsmp", count_log(0, 8), 2);
    enable_timer = 1'b0;
    step(1);
    start_pkt(2, 1);
    step(4);
    chk("c2_smp1", smp_log[1], 1);
    chk("c2_shf2", shf_log[2], 1);
    chk("c2_dn2", dn_log[2], 1);
    chk("c2_nshf", count_log(1, 4), 1);
    enable_timer = 1'b0;
    step(1);

    // Abort in cycle 37, then a fresh packet
    start_pkt(10, 9);
    step(37);
    chk("abt_bitidx37", bit_index, 3);
    enable_timer = 1'b0;
    #2;
    chk("abt_noshf37", shift_strobe, 0);
    chk("abt_nosmp37", sample_strobe, 0);
    step(1);
    chk("abt_idle_busy", busy, 0);
    chk("abt_idle_bitidx", bit_index, 0);
    start_pkt(10, 9);
    step(6);
    chk("abt_restart_smp5", smp_log[5], 1);
    chk("abt_restart_nsmp", count_log(0, 6), 1);
    enable_timer = 1'b0;
    step(2);

    // Illegal configurations held for three cycles each
    cfg_clks_per_bit    = CW'(1);
    cfg_bits_per_packet = BW'(9);
    enable_timer        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ill_cpb_err", cfg_error, 1);
      chk("ill_cpb_busy", busy, 0);
      step(1);
    end
    cfg_clks_per_bit    = CW'(10);
    cfg_bits_per_packet = BW'(0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ill_bpp_err", cfg_error, 1);
      chk("ill_bpp_busy", busy, 0);
      step(1);
    end
    enable_timer = 1'b0;
    step(1);

    // Config change mid-packet is ignored until the next packet
    start_pkt(8, 4);
    step(10);
    cfg_clks_per_bit = CW'(20);
    step(25);
    chk("cfg_shf24", shf_log[24], 1);
    chk("cfg_dn32", dn_log[32], 1);
    chk("cfg_nshf", count_log(1, 35), 4);
    enable_timer = 1'b0;
    step(1);
    start_pkt(20, 4);
    step(81);
    chk("cfg2_shf20", shf_log[20], 1);
    chk("cfg2_dn80", dn_log[80], 1);
    chk("cfg2_ndn", count_log(2, 81), 1);
    enable_timer = 1'b0;
    step(1);

    // Synchronous reset at cycle 25 with enable_timer still high
    start_pkt(10, 9);
    step(25);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("srst_busy", busy, 0);
    chk("srst_bitidx", bit_index, 0);
    chk("srst_strobes", {sample_strobe, shift_strobe, packet_done, cfg_error}, 0);
    step(6);
    chk("srst_rerun_busy", busy, 1);
    enable_timer = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
